pingpong_bank_writer: RTL and testbench

//  Write-side controller for the two 32x8 ping-pong RAMs (ram1/ram2) that the display path reads.
//  - Accepts a valid/ready byte stream from the map/note generator.
//  - Fills one bank while the reader drains the other.
//  - Hands each completed bank to the reader with a length.
//  - Recycles a bank only after the reader releases it with rd_done.

---
 rtl/game_buf_pkg.sv | 15 +
 rtl/bank_status.sv | 55 +++++
 rtl/pingpong_bank_writer.sv | 145 ++++++++++++++
 tb/tb_pingpong_bank_writer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_buf_pkg.sv
// Shared definitions for the game display buffer path.
// Bus widths and writer FSM state codes.
package game_buf_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;

  typedef logic [1:0] wr_state_t;

  localparam wr_state_t ST_FILL   = 2'd0;
  localparam wr_state_t ST_COMMIT = 2'd1;
  localparam wr_state_t ST_WAIT   = 2'd2;

endpackage

// File: rtl/bank_status.sv
// Per-bank full flags, fill lengths and the read pointer.
// Also latches a sticky error on a release with nothing to release.
module bank_status
  import game_buf_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            commit,
  input  logic            commit_bank,
  input  logic [ADDR_W:0] commit_len,
  input  logic            rd_done,
  output logic [1:0]      full,
  output logic            rd_bank,
  output logic            rd_valid,
  output logic [ADDR_W:0] rd_len,
  output logic            err
);

  logic [ADDR_W:0] len0;
  logic [ADDR_W:0] len1;

  // commit marks a bank full; rd_done releases the oldest full bank
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      full    <= 2'b00;
      len0    <= '0;
      len1    <= '0;
      rd_bank <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (commit) begin
        full[commit_bank] <= 1'b1;
        if (commit_bank) len1 <= commit_len;
        else             len0 <= commit_len;
      end
      if (rd_done) begin
        if (full[rd_bank]) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

  // read side view of the bank currently owed to the reader
  always_comb begin
    rd_valid = full[rd_bank];
    rd_len   = rd_bank ? len1 : len0;
  end

endmodule

// File: rtl/pingpong_bank_writer.sv
// Write-side controller for the two ping-pong display RAMs.
// Fills one bank while the reader drains the other.
module pingpong_bank_writer
  import game_buf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic              ram1_write_en,
  output logic [ADDR_W-1:0] ram1_write_address,
  output logic [DATA_W-1:0] ram1_write_data,
  output logic              ram2_write_en,
  output logic [ADDR_W-1:0] ram2_write_address,
  output logic [DATA_W-1:0] ram2_write_data,
  output logic              rd_valid,
  output logic              rd_bank,
  output logic [ADDR_W:0]   rd_len,
  input  logic              rd_done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  wr_state_t         state;
  wr_state_t         state_nxt;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W:0]   pend_len;
  logic              accept;
  logic              commit;
  logic              release_hit;
  logic              other_free;
  logic [1:0]        full;
  logic [1:0]        wr_en;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  // a release on this edge of the other bank counts as free
  always_comb begin
    release_hit = rd_done & full[rd_bank];
    other_free  = ~full[~wr_bank] |
                  (release_hit & (rd_bank != wr_bank));
  end

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_FILL;
    else         state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_FILL: begin
        if (accept && (wr_addr == LAST || flush))
          state_nxt = ST_COMMIT;
        else if (!accept && flush && wr_addr != '0)
          state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_nxt = other_free ? ST_FILL : ST_WAIT;
      end
      ST_WAIT: begin
        if (!full[~wr_bank]) state_nxt = ST_FILL;
      end
      default: state_nxt = ST_FILL;
    endcase
  end

  // state-decoded controls
  always_comb begin
    in_ready = (state == ST_FILL);
    accept   = in_valid & in_ready;
    commit   = (state == ST_COMMIT);
  end

  // fill pointer, pending length and bank swap on re-entry to FILL
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_bank  <= 1'b0;
      wr_addr  <= '0;
      pend_len <= '0;
    end else begin
      if (accept) begin
        pend_len <= {1'b0, wr_addr} + (ADDR_W+1)'(1);
        wr_addr  <= wr_addr + ADDR_W'(1);
      end else if (in_ready && flush) begin
        pend_len <= {1'b0, wr_addr};
      end
      if (state != ST_FILL && state_nxt == ST_FILL) begin
        wr_bank <= ~wr_bank;
        wr_addr <= '0;
      end
    end
  end

  // registered write port, one cycle after acceptance
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_en     <= 2'b00;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en <= {accept & wr_bank, accept & ~wr_bank};
      if (accept) begin
        wr_addr_q <= wr_addr;
        wr_data_q <= in_data;
      end
    end
  end

  // both RAMs share address/data; only the strobe selects the bank
  always_comb begin
    ram1_write_en      = wr_en[0];
    ram1_write_address = wr_addr_q;
    ram1_write_data    = wr_data_q;
    ram2_write_en      = wr_en[1];
    ram2_write_address = wr_addr_q;
    ram2_write_data    = wr_data_q;
  end

  bank_status #(
    .ADDR_W (ADDR_W)
  ) u_status (
    .clk         (clk),
    .resetn      (resetn),
    .commit      (commit),
    .commit_bank (wr_bank),
    .commit_len  (pend_len),
    .rd_done     (rd_done),
    .full        (full),
    .rd_bank     (rd_bank),
    .rd_valid    (rd_valid),
    .rd_len      (rd_len),
    .err         (err)
  );

endmodule

// File: tb/tb_pingpong_bank_writer.sv
// Directed bench for pingpong_bank_writer.
// Expected writes are queued at issue and matched by a monitor.
module tb_pingpong_bank_writer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       flush;
  logic       ram1_write_en;
  logic [4:0] ram1_write_address;
  logic [7:0] ram1_write_data;
  logic       ram2_write_en;
  logic [4:0] ram2_write_address;
  logic [7:0] ram2_write_data;
  logic       rd_valid;
  logic       rd_bank;
  logic [5:0] rd_len;
  logic       rd_done;
  logic       err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [13:0] exp_q[$];

  pingpong_bank_writer dut (
    .clk                (clk),
    .resetn             (resetn),
    .in_valid           (in_valid),
    .in_data            (in_data),
    .in_ready           (in_ready),
    .flush              (flush),
    .ram1_write_en      (ram1_write_en),
    .ram1_write_address (ram1_write_address),
    .ram1_write_data    (ram1_write_data),
    .ram2_write_en      (ram2_write_en),
    .ram2_write_address (ram2_write_address),
    .ram2_write_data    (ram2_write_data),
    .rd_valid           (rd_valid),
    .rd_bank            (rd_bank),
    .rd_len             (rd_len),
    .rd_done            (rd_done),
    .err                (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // monitor: every write strobe must match the oldest expectation
  always @(negedge clk) begin
    if (resetn === 1'b1 &&
        (ram1_write_en || ram2_write_en)) begin
      logic [13:0] e;
      logic [13:0] a;
      if (ram1_write_en && ram2_write_en) begin
        n_chk++;
        n_fail++;
        $display("FAIL dual_write: both strobes high");
      end else if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL stray_write: bank %0d addr %0d",
                 ram2_write_en, ram1_write_address);
      end else begin
        e = exp_q.pop_front();
        if (ram1_write_en)
          a = {1'b0, ram1_write_address, ram1_write_data};
        else
          a = {1'b1, ram2_write_address, ram2_write_data};
        chk("write", 32'(a), 32'(e));
      end
    end
  end

  // called at a negedge; returns at the negedge after acceptance
  task automatic send(input logic [7:0] d, input logic eb,
                      input logic [4:0] ea, input logic f = 1'b0);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    flush    = f;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: in_ready %0b required 1",
               in_ready);
    end else begin
      exp_q.push_back({eb, ea, d});
      @(negedge clk);
    end
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic pulse_done();
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
  endtask

  initial begin
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    flush    = 1'b0;
    rd_done  = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_we1", ram1_write_en, 0);
    chk("rst_we2", ram2_write_en, 0);
    chk("rst_addr", ram1_write_address, 0);
    chk("rst_data", ram2_write_data, 0);
    chk("rst_rdv", rd_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_len", rd_len, 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_bank", rd_bank, 0);

    // full bank 0
    for (int i = 0; i < 32; i++)
      send(8'(i), 1'b0, 5'(i));
    chk("t2_commit_ready", in_ready, 0);
    chk("t2_rdv_early", rd_valid, 0);
    @(negedge clk);
    chk("t2_rdv", rd_valid, 1);
    chk("t2_bank", rd_bank, 0);
    chk("t2_len", rd_len, 32);
    chk("t2_ready", in_ready, 1);

    // bank 1 fills, writer then waits on bank 0
    for (int i = 0; i < 32; i++)
      send(8'(8'h20 + i), 1'b1, 5'(i));
    repeat (3) begin
      @(negedge clk);
      chk("t3_wait", in_ready, 0);
    end
    pulse_done();
    chk("t3_bank", rd_bank, 1);
    chk("t3_len", rd_len, 32);
    chk("t3_rdv", rd_valid, 1);
    chk("t3_still_wait", in_ready, 0);
    @(negedge clk);
    chk("t3_ready", in_ready, 1);
    send(8'hA0, 1'b0, 5'd0);

    // partial fill closed by flush
    for (int i = 1; i < 5; i++)
      send(8'(8'hA0 + i), 1'b0, 5'(i));
    pulse_done();
    chk("t4_rel_rdv", rd_valid, 0);
    chk("t4_rel_bank", rd_bank, 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t4_commit", in_ready, 0);
    @(negedge clk);
    chk("t4_rdv", rd_valid, 1);
    chk("t4_len", rd_len, 5);
    chk("t4_bank", rd_bank, 0);
    chk("t4_ready", in_ready, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t4_idle_flush", in_ready, 1);
    @(negedge clk);
    chk("t4_idle_ready", in_ready, 1);
    chk("t4_idle_len", rd_len, 5);

    // flush with accept, release in the COMMIT cycle
    send(8'hB0, 1'b1, 5'd0);
    send(8'hB1, 1'b1, 5'd1);
    send(8'hB2, 1'b1, 5'd2, 1'b1);
    chk("t5_commit", in_ready, 0);
    pulse_done();
    chk("t5_ready", in_ready, 1);
    chk("t5_bank", rd_bank, 1);
    chk("t5_len", rd_len, 3);
    chk("t5_rdv", rd_valid, 1);
    send(8'hC0, 1'b0, 5'd0);

    // error flag and mid-fill reset
    pulse_done();
    chk("t6_rdv", rd_valid, 0);
    chk("t6_err0", err, 0);
    pulse_done();
    chk("t6_err1", err, 1);
    repeat (2) @(negedge clk);
    chk("t6_sticky", err, 1);
    for (int i = 1; i < 12; i++)
      send(8'(8'hD0 + i), 1'b0, 5'(i));
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("t6_rst_err", err, 0);
    chk("t6_rst_rdv", rd_valid, 0);
    chk("t6_rst_we", ram1_write_en, 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_ready", in_ready, 1);
    chk("t6_bank", rd_bank, 0);
    chk("t6_len", rd_len, 0);
    send(8'hE0, 1'b0, 5'd0);
    repeat (3) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
